// File: rtl/tst_din_gen.sv
// ---------------------------------------------------------------------------
// tst_din_gen
// AIE-clock-domain test-data source. While test_en_aie is high it streams
// back-to-back frames of FRAME_BEATS beats over AXI4-Stream and counts every
// completed frame on itecnt_aie, which is carried to the register domain.
//
// Optional feature macro: TST_DIN_PRBS_EN
//   undefined : lane k of beat b carries (b*LANES + k) mod 2^SAMP_W
//   defined   : every lane carries a continuous PRBS-31 (x^31+x^28+1) stream
//
// Ports
//   clk_aie        in   AIE-domain clock
//   rst_aie        in   synchronous, active-high reset
//   test_en_aie    in   level enable, already synchronized to clk_aie
//   m_axis_tdata   out  DATA_W sample data, lane k = [k*SAMP_W +: SAMP_W]
//   m_axis_tvalid  out  AXIS valid
//   m_axis_tlast   out  high on the last beat of each frame
//   m_axis_tready  in   AXIS ready
//   itecnt_aie     out  completed-frame count (changes at most once a frame)
//   busy_aie       out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module tst_din_gen #(
  parameter int DATA_W      = 128,
  parameter int SAMP_W      = 32,
  parameter int FRAME_BEATS = 4096
) (
  input  logic              clk_aie,
  input  logic              rst_aie,
  input  logic              test_en_aie,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [31:0]       itecnt_aie,
  output logic              busy_aie
);

  localparam int LANES  = DATA_W / SAMP_W;
  localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  logic [BEAT_W-1:0] beat_r;
  logic [DATA_W-1:0] tdata_r;
  logic              tvalid_r;
  logic              tlast_r;
  logic [31:0]       itecnt_r;
  logic              busy_r;

  logic              hs_s;
  logic              last_hs_s;
  logic [BEAT_W-1:0] beat_nxt_s;
  logic [DATA_W-1:0] data_start_s;
  logic [DATA_W-1:0] data_nxt_s;

`ifdef TST_DIN_PRBS_EN
  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  logic [30:0] lfsr_r;
  logic [30:0] lfsr_start_s;
  logic [30:0] lfsr_nxt_s;

  // Produces one beat of PRBS-31 from state s_in: SAMP_W bits per lane in
  // lane order, first generated bit in the lane MSB. Returns {state, data}.
  function automatic logic [31+DATA_W-1:0] prbs_beat(input logic [30:0] s_in);
    logic [30:0]       s;
    logic [DATA_W-1:0] d;
    logic              fb;
    s = s_in;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < SAMP_W; j++) begin
        fb = s[30] ^ s[27];
        s  = {s[29:0], fb};
        d[k*SAMP_W + (SAMP_W - 1 - j)] = fb;
      end
    end
    return {s, d};
  endfunction
`else
  // Ramp beat: lane k of beat b carries the sample index b*LANES + k.
  function automatic logic [DATA_W-1:0] ramp_beat(input logic [BEAT_W-1:0] b);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      d[k*SAMP_W +: SAMP_W] = SAMP_W'(32'(b) * 32'(LANES) + 32'(k));
    end
    return d;
  endfunction
`endif

  // Handshake detection and the data for the beat that follows it.
  always_comb begin
    hs_s      = tvalid_r & m_axis_tready;
    last_hs_s = hs_s & (beat_r == LAST_BEAT);
    if (beat_r == LAST_BEAT) begin
      beat_nxt_s = '0;
    end else begin
      beat_nxt_s = beat_r + BEAT_W'(1);
    end
`ifdef TST_DIN_PRBS_EN
    {lfsr_start_s, data_start_s} = prbs_beat(PRBS_SEED);
    {lfsr_nxt_s, data_nxt_s}     = prbs_beat(lfsr_r);
`else
    data_start_s = ramp_beat('0);
    data_nxt_s   = ramp_beat(beat_nxt_s);
`endif
  end

  // Control FSM with registered AXIS outputs and the frame counter.
  always_ff @(posedge clk_aie) begin
    if (rst_aie) begin
      state_r  <= IDLE;
      beat_r   <= '0;
      tdata_r  <= '0;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      itecnt_r <= 32'd0;
      busy_r   <= 1'b0;
`ifdef TST_DIN_PRBS_EN
      lfsr_r   <= PRBS_SEED;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (test_en_aie) begin
            state_r  <= RUN;
            busy_r   <= 1'b1;
            tvalid_r <= 1'b1;
            tlast_r  <= (LAST_BEAT == '0);
            beat_r   <= '0;
            tdata_r  <= data_start_s;
            itecnt_r <= 32'd0;
`ifdef TST_DIN_PRBS_EN
            lfsr_r   <= lfsr_start_s;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN, DRAIN: begin
          // Beat data only moves on a handshake, so a stalled beat is held
          // regardless of what test_en_aie does meanwhile.
          if (hs_s) begin
            beat_r  <= beat_nxt_s;
            tdata_r <= data_nxt_s;
            tlast_r <= (beat_nxt_s == LAST_BEAT);
`ifdef TST_DIN_PRBS_EN
            lfsr_r  <= lfsr_nxt_s;
`endif
          end else begin
            beat_r <= beat_r;
          end
          if (last_hs_s) begin
            itecnt_r <= itecnt_r + 32'd1;
          end else begin
            itecnt_r <= itecnt_r;
          end
          // Disable only takes effect at a frame boundary; until then DRAIN
          // keeps streaming and re-enabling resumes RUN without a clear.
          if (!test_en_aie && last_hs_s) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            tdata_r  <= '0;
            beat_r   <= '0;
          end else if (!test_en_aie) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
          tdata_r  <= '0;
          beat_r   <= '0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = tdata_r;
  assign m_axis_tvalid = tvalid_r;
  assign m_axis_tlast  = tlast_r;
  assign itecnt_aie    = itecnt_r;
  assign busy_aie      = busy_r;

endmodule

// File: tb/tb_tst_din_gen.sv
// ---------------------------------------------------------------------------
// tb_tst_din_gen
// Scoreboard bench for tst_din_gen with FRAME_BEATS=4, DATA_W=128,
// SAMP_W=32. Stimulus pushes the expected beats of every frame it expects
// the DUT to send; a negedge monitor pops and compares on each handshake and
// checks that stalled beats stay stable. With TST_DIN_PRBS_EN defined the
// expected lanes come from a PRBS-31 reference model instead of the ramp.
// ---------------------------------------------------------------------------
module tb_tst_din_gen;

  localparam int DATA_W = 128;
  localparam int SAMP_W = 32;
  localparam int FB     = 4;

  logic              clk;
  logic              rst_aie;
  logic              test_en_aie;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [31:0]       itecnt_aie;
  logic              busy_aie;

  int n_tests  = 0;
  int n_fail   = 0;
  int hs_count = 0;

  logic [DATA_W:0] exp_q[$];   // {tlast, tdata}
  logic [30:0]     m_lfsr;

  logic              stall_r  = 1'b0;
  logic [DATA_W-1:0] held_d_r = '0;
  logic              held_l_r = 1'b0;

  tst_din_gen #(
    .DATA_W(DATA_W),
    .SAMP_W(SAMP_W),
    .FRAME_BEATS(FB)
  ) dut (
    .clk_aie(clk),
    .rst_aie(rst_aie),
    .test_en_aie(test_en_aie),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .itecnt_aie(itecnt_aie),
    .busy_aie(busy_aie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W:0] act, input logic [DATA_W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected beat b of a frame: ramp lanes, or next PRBS beat from the model.
  task automatic exp_beat(input int b, output logic [DATA_W-1:0] d);
    logic fb;
    d = '0;
    for (int k = 0; k < DATA_W/SAMP_W; k++) begin
`ifdef TST_DIN_PRBS_EN
      for (int j = 0; j < SAMP_W; j++) begin
        fb     = m_lfsr[30] ^ m_lfsr[27];
        m_lfsr = {m_lfsr[29:0], fb};
        d[k*SAMP_W + SAMP_W - 1 - j] = fb;
      end
`else
      fb = 1'b0;
      d[k*SAMP_W +: SAMP_W] = 32'(b * 4 + k);
`endif
    end
  endtask

  task automatic push_frames(input int n, input bit reseed);
    logic [DATA_W-1:0] d;
    if (reseed) m_lfsr = 31'h7FFF_FFFF;
    for (int f = 0; f < n; f++) begin
      for (int b = 0; b < FB; b++) begin
        exp_beat(b, d);
        exp_q.push_back({(b == FB - 1), d});
      end
    end
  endtask

  // One cycle: land just after the negedge, once the monitor has updated.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_hs(input int n);
    int c;
    c = 0;
    while (hs_count < n && c < 2000) begin
      step();
      c++;
    end
    chk("wait_handshakes", 129'(hs_count >= n), 129'(1));
  endtask

  // Monitor: compare each handshaken beat with the scoreboard, and check
  // that a beat stalled on the previous negedge is still presented unchanged.
  always @(negedge clk) begin : monitor
    logic [DATA_W:0] e;
    if (stall_r && !rst_aie) begin
      chk("stall_valid", 129'(m_axis_tvalid), 129'(1));
      chk("stall_data", 129'(m_axis_tdata), 129'(held_d_r));
      chk("stall_last", 129'(m_axis_tlast), 129'(held_l_r));
    end
    stall_r  <= m_axis_tvalid && !m_axis_tready;
    held_d_r <= m_axis_tdata;
    held_l_r <= m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      hs_count <= hs_count + 1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 129'(m_axis_tdata), 129'(e[DATA_W-1:0]));
        chk("beat_last", 129'(m_axis_tlast), 129'(e[DATA_W]));
      end
    end
  end

  initial begin
    int base;
    int c;
    rst_aie       = 1'b1;
    test_en_aie   = 1'b0;
    m_axis_tready = 1'b1;
    m_lfsr        = 31'h7FFF_FFFF;
    repeat (3) step();
    chk("rst_tvalid", 129'(m_axis_tvalid), 129'(0));
    chk("rst_tlast", 129'(m_axis_tlast), 129'(0));
    chk("rst_tdata", 129'(m_axis_tdata), 129'(0));
    chk("rst_itecnt", 129'(itecnt_aie), 129'(0));
    chk("rst_busy", 129'(busy_aie), 129'(0));
    rst_aie = 1'b0;
    step();

    // Start, two full frames, then drop enable during beat 1 of frame 3.
    push_frames(3, 1'b1);
    test_en_aie = 1'b1;
    step();
    chk("start_tvalid", 129'(m_axis_tvalid), 129'(1));
    chk("start_busy", 129'(busy_aie), 129'(1));
    chk("start_itecnt", 129'(itecnt_aie), 129'(0));
    wait_hs(4);
    step();
    chk("itecnt_frame1", 129'(itecnt_aie), 129'(1));
    wait_hs(8);
    step();
    chk("itecnt_frame2", 129'(itecnt_aie), 129'(2));
    wait_hs(10);
    test_en_aie = 1'b0;
    step();
    chk("drain_busy", 129'(busy_aie), 129'(1));
    chk("drain_tvalid", 129'(m_axis_tvalid), 129'(1));
    wait_hs(12);
    step();
    chk("stop_itecnt", 129'(itecnt_aie), 129'(3));
    chk("stop_tvalid", 129'(m_axis_tvalid), 129'(0));
    chk("stop_busy", 129'(busy_aie), 129'(0));
    chk("stop_tlast", 129'(m_axis_tlast), 129'(0));
    repeat (3) step();
    chk("idle_itecnt_hold", 129'(itecnt_aie), 129'(3));
    chk("idle_tvalid", 129'(m_axis_tvalid), 129'(0));
    chk("queue_empty_1", 129'(exp_q.size()), 129'(0));

    // Re-enable: count clears, pattern restarts; DRAIN toggle in frame 2.
    base = hs_count;
    push_frames(20, 1'b1);
    test_en_aie = 1'b1;
    step();
    chk("reen_itecnt", 129'(itecnt_aie), 129'(0));
    chk("reen_busy", 129'(busy_aie), 129'(1));
    wait_hs(base + 5);
    test_en_aie = 1'b0;
    step();
    chk("toggle_drain_busy", 129'(busy_aie), 129'(1));
    chk("toggle_drain_tvalid", 129'(m_axis_tvalid), 129'(1));
    test_en_aie = 1'b1;
    step();
    chk("toggle_no_clear", 129'(itecnt_aie), 129'(1));

    // Random tready for the rest of the 20 frames; stop inside frame 20.
    c = 0;
    while (hs_count < base + 80 && c < 5000) begin
      @(posedge clk);
      #1;
      if (hs_count >= base + 77) test_en_aie = 1'b0;
      m_axis_tready = 1'($urandom_range(0, 1));
      c++;
    end
    chk("random_done", 129'(hs_count >= base + 80), 129'(1));
    m_axis_tready = 1'b1;
    step();
    step();
    chk("random_itecnt", 129'(itecnt_aie), 129'(20));
    chk("random_tvalid", 129'(m_axis_tvalid), 129'(0));
    chk("random_busy", 129'(busy_aie), 129'(0));
    chk("queue_empty_2", 129'(exp_q.size()), 129'(0));

    // Reset while beat 2 is on the bus, then restart with enable held.
    base = hs_count;
    push_frames(1, 1'b1);
    test_en_aie = 1'b1;
    wait_hs(base + 3);
    rst_aie = 1'b1;
    step();
    chk("mid_rst_tvalid", 129'(m_axis_tvalid), 129'(0));
    chk("mid_rst_tlast", 129'(m_axis_tlast), 129'(0));
    chk("mid_rst_itecnt", 129'(itecnt_aie), 129'(0));
    chk("mid_rst_busy", 129'(busy_aie), 129'(0));
    chk("mid_rst_tdata", 129'(m_axis_tdata), 129'(0));
    chk("truncated_left", 129'(exp_q.size()), 129'(1));
    exp_q.delete();
    push_frames(1, 1'b1);
    rst_aie = 1'b0;
    wait_hs(base + 7);
    // Enable low on the same edge as the tlast handshake: straight to IDLE.
    test_en_aie = 1'b0;
    step();
    chk("post_rst_itecnt", 129'(itecnt_aie), 129'(1));
    chk("post_rst_tvalid", 129'(m_axis_tvalid), 129'(0));
    chk("post_rst_busy", 129'(busy_aie), 129'(0));
    chk("queue_empty_3", 129'(exp_q.size()), 129'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
